// File: rtl/spi_master.sv
// SPI initiator: one 8-bit full-duplex word per start, MSB first, sclk idles low.
// sclk half-period is CLK_DIV clk cycles; cpha selects which sclk edge samples miso.
module spi_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_cpha,
  input  logic [7:0] i_masterDataIN,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_mosi,
  output logic       o_cs,
  output logic [7:0] o_masterDataOUT,
  output logic       o_busy,
  output logic       o_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [DW-1:0] r_div;
  logic [4:0]    r_edge;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic          r_cpha;

  logic          w_tick;
  logic          w_accept;
  logic          w_edge;
  logic          w_rising;
  logic          w_sample;
  logic          w_update;
  logic [4:0]    w_k;

  // Half-period tick and per-edge sample/update decisions; w_k is the edge about to occur.
  always_comb begin
    w_tick   = (r_state != S_IDLE) && (r_div == DIV_LAST);
    w_accept = (r_state == S_IDLE) && i_start;
    w_edge   = w_tick && ((r_state == S_SETUP) || (r_state == S_SHIFT));
    w_k      = r_edge + 5'd1;
    w_rising = w_k[0];
    if (r_cpha) begin
      w_sample = w_edge && w_rising;
      w_update = w_edge && !w_rising && (w_k <= 5'd14);
    end else begin
      w_sample = w_edge && !w_rising;
      w_update = w_edge && w_rising && (w_k >= 5'd3);
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_SETUP;
        else         w_next = S_IDLE;
      end
      S_SETUP: begin
        if (w_tick) w_next = S_SHIFT;
        else        w_next = S_SETUP;
      end
      S_SHIFT: begin
        if (w_tick && (w_k == 5'd16)) w_next = S_HOLD;
        else                          w_next = S_SHIFT;
      end
      S_HOLD: begin
        if (w_tick) w_next = S_IDLE;
        else        w_next = S_HOLD;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Divider, shift registers and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div           <= '0;
      r_edge          <= 5'd0;
      r_tx            <= 8'h00;
      r_rx            <= 8'h00;
      r_cpha          <= 1'b0;
      o_sclk          <= 1'b0;
      o_mosi          <= 1'b0;
      o_cs            <= 1'b1;
      o_masterDataOUT <= 8'h00;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if ((r_state == S_IDLE) || w_tick) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (w_accept) begin
        r_tx   <= i_masterDataIN;
        r_cpha <= i_cpha;
        r_rx   <= 8'h00;
        r_edge <= 5'd0;
        o_cs   <= 1'b0;
        o_mosi <= i_masterDataIN[7];
        o_busy <= 1'b1;
      end
      if (w_edge) begin
        o_sclk <= ~o_sclk;
        r_edge <= w_k;
      end
      // miso is taken as registered on the toggling edge, i.e. before sclk changes.
      if (w_sample) begin
        r_rx <= {r_rx[6:0], i_miso};
      end
      if (w_update) begin
        r_tx   <= {r_tx[6:0], 1'b0};
        o_mosi <= r_tx[6];
      end
      if ((r_state == S_HOLD) && w_tick) begin
        o_cs            <= 1'b1;
        o_masterDataOUT <= r_rx;
        o_done          <= 1'b1;
        o_busy          <= 1'b0;
        r_edge          <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench: two spi_master instances (CLK_DIV 2 and 1) each talk to a
// behavioural SPI slave; random words are exchanged and checked against what each side sent.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cpha = 1'b0;
  logic [7:0] din = 8'h00;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic [7:0] cur_tx = 8'h00;
  logic [7:0] cur_pat = 8'h00;
  logic       cur_cpha = 1'b0;
  logic       cur_loop = 1'b0;
  logic       chk_gap = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  for (genvar j = 0; j < 2; j++) begin : g_mon
    localparam int D = (j == 0) ? 2 : 1;
    logic       sclk, mosi, cs, busy, done;
    logic       miso;
    logic [7:0] dout;
    logic       cs_p, sclk_p, mosi_p, m_cpha, m_loop, rising, upd, b2b_rise;
    logic [7:0] stx, srx, m_pat, m_tx;
    int         t0 = 0;
    int         e = 0;
    int         n_done = 0;

    spi_master #(.CLK_DIV(D)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_cpha(cpha),
      .i_masterDataIN(din), .i_miso(miso),
      .o_sclk(sclk), .o_mosi(mosi), .o_cs(cs), .o_masterDataOUT(dout),
      .o_busy(busy), .o_done(done)
    );

    // Slave model plus timing monitor, evaluated between active edges.
    always @(negedge clk) begin
      if (rst) begin
        e = 0; cs_p = 1'b1; sclk_p = 1'b0; mosi_p = 1'b0; miso = 1'b0; b2b_rise = 1'b0;
      end else begin
        if (!chk_gap) b2b_rise = 1'b0;
        if (done) begin
          n_done++;
          check_val("done_when", cyc, t0 + 17 * D);
        end
        if (cs_p && !cs) begin
          t0 = cyc; e = 0;
          m_cpha = cur_cpha; m_loop = cur_loop; m_pat = cur_pat; m_tx = cur_tx;
          stx = cur_pat; srx = 8'h00;
          check_val("mosi_first", mosi, m_tx[7]);
          check_val("busy_on", busy, 1'b1);
          if (chk_gap && b2b_rise) check_val("cs_gap", cyc - t0 + 1, 1);
          miso = m_loop ? mosi : stx[7];
        end else if (!cs_p && cs) begin
          if (chk_gap) b2b_rise = 1'b1;
          check_val("t_done", cyc, t0 + 17 * D);
          check_val("n_edges", e, 16);
          check_val("rx_out", dout, m_loop ? m_tx : m_pat);
          check_val("slave_rx", srx, m_tx);
          check_val("end_flags", {done, busy, sclk}, 3'b100);
          check_val("mosi_hold", mosi, mosi_p);
        end else if (!cs) begin
          upd = 1'b0;
          if (sclk != sclk_p) begin
            e++;
            check_val("t_edge", cyc, t0 + e * D);
            rising = sclk;
            upd = m_cpha ? (!rising && e <= 14) : (rising && e >= 3);
            if (m_cpha == rising) srx = {srx[6:0], mosi_p};
            if (upd) stx = {stx[6:0], 1'b0};
          end
          if (mosi != mosi_p) check_val("mosi_edge", upd, 1'b1);
          miso = m_loop ? mosi : stx[7];
        end
        cs_p = cs; sclk_p = sclk; mosi_p = mosi;
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      ok = g_mon[0].cs && g_mon[1].cs && !g_mon[0].busy && !g_mon[1].busy;
    end
    repeat (2) @(negedge clk);
    check_val("idle_reached", ok, 1'b1);
  endtask

  task automatic set_cur(input logic [7:0] tx, input logic [7:0] pat, input logic cp, input logic lp);
    cur_tx = tx; cur_pat = pat; cur_cpha = cp; cur_loop = lp;
    din = tx; cpha = cp;
  endtask

  task automatic run_xfer(input logic [7:0] tx, input logic [7:0] pat, input logic cp, input logic lp);
    int d0, d1;
    d0 = g_mon[0].n_done; d1 = g_mon[1].n_done;
    set_cur(tx, pat, cp, lp);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();
    check_val("done_once0", g_mon[0].n_done - d0, 1);
    check_val("done_once1", g_mon[1].n_done - d1, 1);
  endtask

  task automatic check_reset_vals();
    check_val("rst_vals0", {g_mon[0].cs, g_mon[0].sclk, g_mon[0].mosi, g_mon[0].busy,
                            g_mon[0].done, g_mon[0].dout}, 13'h1000);
    check_val("rst_vals1", {g_mon[1].cs, g_mon[1].sclk, g_mon[1].mosi, g_mon[1].busy,
                            g_mon[1].done, g_mon[1].dout}, 13'h1000);
  endtask

  initial begin
    int d0, d1;
    bit hit;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;

    run_xfer(8'hA5, 8'h00, 1'b0, 1'b1);
    run_xfer(8'hC3, 8'h3C, 1'b0, 1'b0);
    run_xfer(8'h81, 8'h5A, 1'b1, 1'b0);
    run_xfer(8'h00, 8'hFF, 1'b1, 1'b0);
    run_xfer(8'hFF, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      run_xfer(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end

    // A second start during busy, with changed data and phase, must be ignored.
    d0 = g_mon[0].n_done; d1 = g_mon[1].n_done;
    set_cur(8'h6E, 8'h93, 1'b0, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; din = 8'h11; cpha = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_idle();
    check_val("busy_ignore0", g_mon[0].n_done - d0, 1);
    check_val("busy_ignore1", g_mon[1].n_done - d1, 1);

    // Start held high: back-to-back transfers with one idle cycle of cs between.
    d0 = g_mon[0].n_done; d1 = g_mon[1].n_done;
    set_cur(8'hB4, 8'h2D, 1'b1, 1'b0);
    chk_gap = 1'b1;
    @(negedge clk); start = 1'b1;
    repeat (80) @(negedge clk);
    start = 1'b0;
    wait_idle();
    chk_gap = 1'b0;
    check_val("b2b_count0", g_mon[0].n_done - d0, 3);
    check_val("b2b_count1", g_mon[1].n_done - d1, 5);

    // Asynchronous reset in the middle of a transfer.
    d0 = g_mon[0].n_done;
    set_cur(8'h5C, 8'hE7, 1'b0, 1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      hit = (g_mon[0].e >= 9);
    end
    check_val("edge9_reached", hit, 1'b1);
    #2 rst = 1'b1;
    #1 check_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_val("no_done_on_rst", g_mon[0].n_done - d0, 0);
    run_xfer(8'h3A, 8'hC6, 1'b1, 1'b0);
    run_xfer(8'($urandom), 8'($urandom), 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
